// File: rtl/pushbutton_debouncer.sv
// pushbutton_debouncer: synchronise, tick-filter and edge-strobe raw pushbutton inputs
module pushbutton_debouncer #(
  parameter int   WIDTH          = 4,
  parameter int   TICK_DIV       = 50000,
  parameter int   DEBOUNCE_TICKS = 20,
  parameter logic IDLE_LEVEL     = 1'b1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] btn_raw,
  output logic [WIDTH-1:0] btn_out,
  output logic [WIDTH-1:0] press_pulse,
  output logic [WIDTH-1:0] release_pulse,
  output logic             tick
);
  localparam int PW = TICK_DIV > 1 ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PRE_MAX = PW'(TICK_DIV - 1);
  localparam logic [7:0] CNT_MAX = 8'(DEBOUNCE_TICKS - 1);
  logic [PW-1:0] pre_q, pre_d;
  logic [WIDTH-1:0] sync1_q, sync2_q, btn_q, btn_d, press_q, press_d, release_q, release_d;
  logic [WIDTH-1:0][7:0] cnt_q, cnt_d;
  assign tick = pre_q == PRE_MAX;
  assign pre_d = tick ? '0 : pre_q + 1'b1;
  assign btn_out = btn_q;
  assign press_pulse = press_q;
  assign release_pulse = release_q;
  // per-channel stability count: restart on agreement, accept on the last required tick
  always_comb begin
    btn_d = btn_q;
    cnt_d = cnt_q;
    press_d = '0;
    release_d = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (sync2_q[i] == btn_q[i]) cnt_d[i] = '0;
      else if (tick && cnt_q[i] == CNT_MAX) begin
        btn_d[i] = sync2_q[i];
        cnt_d[i] = '0;
        press_d[i] = sync2_q[i] != IDLE_LEVEL;
        release_d[i] = sync2_q[i] == IDLE_LEVEL;
      end
      else if (tick) cnt_d[i] = cnt_q[i] + 8'd1;
    end
  end
  // state registers; reset discards any pending count and emits no strobes
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pre_q <= '0;
      sync1_q <= {WIDTH{IDLE_LEVEL}};
      sync2_q <= {WIDTH{IDLE_LEVEL}};
      btn_q <= {WIDTH{IDLE_LEVEL}};
      cnt_q <= '0;
      press_q <= '0;
      release_q <= '0;
    end else begin
      pre_q <= pre_d;
      sync1_q <= btn_raw;
      sync2_q <= sync1_q;
      btn_q <= btn_d;
      cnt_q <= cnt_d;
      press_q <= press_d;
      release_q <= release_d;
    end
  end
endmodule

// File: doc/pushbutton_debouncer.md
# pushbutton_debouncer

Multi-channel debouncer between the raw board pushbutton pins and the pushbutton PIO's `in_port`. Each raw input is synchronised into `clk` and filtered with a shared millisecond-scale tick prescaler and a per-channel stability counter. The block emits a clean, glitch-free level bus for the PIO edge-capture logic, plus one-cycle press and release strobes for local fabric consumers.

## Interface
- `WIDTH`, 4: number of button channels.
- `TICK_DIV`, 50000: clk cycles per debounce tick (1 ms at 50 MHz). Legal range is ≥1.
- `DEBOUNCE_TICKS`, 20: consecutive ticks of stable difference required to accept a change. Legal range is 1..255.
- `IDLE_LEVEL`, 1'b1: released level of every button (board buttons are active-low).

- `clk` in 1: system clock.
- `reset_n` in 1: asynchronous, active-low reset.
- `btn_raw` in WIDTH: asynchronous raw button pins.
- `btn_out` out WIDTH: debounced level. Connects to the PIO `in_port`.
- `press_pulse` out WIDTH: one-cycle strobe when a channel leaves `IDLE_LEVEL`.
- `release_pulse` out WIDTH: one-cycle strobe when a channel returns to `IDLE_LEVEL`.
- `tick` out 1: prescaler tick, exported for other slow-rate logic.

## Operation
- **Synchroniser.** Each channel has a 2-flop chain `sync1 -> sync2`. Both flops reset to `IDLE_LEVEL`. All filtering uses `sync2` only.
- **Prescaler.**
  - Counter `pre` runs 0..TICK_DIV-1, wraps to 0, and resets to 0.
  - `tick` = (`pre` == TICK_DIV-1), decoded combinationally from the register.
  - With TICK_DIV=1, `tick` is constantly 1 after reset.
- **Per-channel counter `cnt[i]`.** Width 8, reset 0. Each cycle, evaluated in priority order:
  - If `sync2[i]` == `btn_out[i]`: `cnt[i]` <= 0.
  - Else if `tick` and `cnt[i]` == DEBOUNCE_TICKS-1: `btn_out[i]` <= `sync2[i]` and `cnt[i]` <= 0.
  - Else if `tick`: `cnt[i]` <= `cnt[i]` + 1.
  - Otherwise `cnt[i]` holds.
- **Filtering guarantees.**
  - Any return to agreement restarts the count from zero.
  - A difference lasting fewer than DEBOUNCE_TICKS ticks never reaches `btn_out`.
  - `cnt[i]` never exceeds DEBOUNCE_TICKS-1, so it cannot wrap.
- **Strobes.** Registered on the same edge as the `btn_out[i]` change:
  - `press_pulse[i]` = 1 if the new value is !IDLE_LEVEL.
  - `release_pulse[i]` = 1 if the new value is IDLE_LEVEL.
  - Both are 0 in every other cycle. They are never asserted together on one channel.
- **Channel independence.** Channels are fully independent and share only `tick`. Changes on several channels in the same cycle produce strobes on all of them in that cycle.
- **Reset values.** `btn_out` = {WIDTH{IDLE_LEVEL}}, `press_pulse` = 0, `release_pulse` = 0, `cnt` = 0, `pre` = 0.
- **Reset mid-operation.** A reset during a pending count discards that count. The strobes for that event are never emitted, and no strobe is generated on reset release.

## Timing
- Synchroniser latency: `sync2` reflects `btn_raw` 2 edges after the pin change.
- Accept latency: `btn_out` changes at the clock edge carrying the DEBOUNCE_TICKS-th tick after `sync2` first differs. That is between 2 + (DEBOUNCE_TICKS-1)·TICK_DIV + 1 and 2 + DEBOUNCE_TICKS·TICK_DIV cycles after a clean pin change.
- Strobe: exactly 1 cycle wide, aligned with the `btn_out` transition.
- Minimum spacing between two accepted changes on one channel: DEBOUNCE_TICKS ticks.
- `btn_out` is registered and glitch-free. There is no combinational path from `btn_raw` to any output.
- Downstream PIO: its falling-edge detect sees exactly one edge per accepted press when IDLE_LEVEL=1.

## Test plan
All scenarios use TICK_DIV=4, DEBOUNCE_TICKS=3, WIDTH=4, IDLE_LEVEL=1 unless stated otherwise.

1. **Reset.** Hold `reset_n`=0 with `btn_raw`=4'b0000, then release. Required: `btn_out`=4'b1111 and no strobes during reset or in the cycles after release. `btn_out[*]` then falls 11–14 cycles after release, with a single `press_pulse` on each channel.
2. **Clean press and release.** Drive `btn_raw[0]` 1->0 and hold it. Required: `btn_out[0]` falls 11–14 cycles later, with `press_pulse`=4'b0001 for one cycle. Then drive it 0->1. Required: the mirror response with `release_pulse`=4'b0001.
3. **Bounce rejection.**
   - Drive `btn_raw[1]` low for 6 cycles, then high. Required: `btn_out` and the strobes stay unchanged.
   - Then drive bursts of 1–5 cycles low separated by 1-cycle highs. Required: no output change until the line is held low continuously, after which exactly one `press_pulse[1]` is emitted.
4. **Simultaneous channels.** Drive `btn_raw` 4'b1111 -> 4'b0101 on one edge. Required: `btn_out` = 4'b0101 on a single edge, with `press_pulse`=4'b1010 for exactly one cycle.
5. **Reset mid-count.** Drive `btn_raw[2]` low, then assert `reset_n` for 1 cycle at cycle 8 of the count. Required: no strobe is emitted before the reset, and `btn_out` reads 4'b1111 during the reset. The press is then re-accepted 11–14 cycles after reset release.
6. **Degenerate parameters.** Set TICK_DIV=1, DEBOUNCE_TICKS=1. Required: `tick` stays 1, and `btn_out` follows `btn_raw` exactly 3 cycles late. A 1-cycle pulse on `btn_raw` passes through as a 1-cycle `btn_out` pulse, producing `press_pulse` then `release_pulse` on consecutive cycles.
